// File: rtl/im2_vector_responder_if.sv
// -----------------------------------------------------------------------------
// im2_vector_responder_if
// Groups the request lines, Z80 bus inputs and responder outputs of the IM2
// vector responder into one bundle.
//   src_req  : peripheral request lines (rising edge sets pending)
//   cpu_a    : CPU address bus
//   cpu_d_in : CPU write data
//   cpu_m1 / cpu_iorq / cpu_rd / cpu_wr : active-high bus strobes
//   int_req  : level interrupt request toward the CPU INT path
//   d_out    : byte driven toward the CPU when d_oe is high
//   d_oe     : data bus drive enable
//   ack_src  : index of the most recently acknowledged source
//   ack_stb  : one-cycle pulse per real acknowledge
// Modports: master = CPU/peripheral side, slave = responder.
// -----------------------------------------------------------------------------
interface im2_vector_responder_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] src_req;
    logic [15:0]     cpu_a;
    logic [7:0]      cpu_d_in;
    logic            cpu_m1;
    logic            cpu_iorq;
    logic            cpu_rd;
    logic            cpu_wr;
    logic            int_req;
    logic [7:0]      d_out;
    logic            d_oe;
    logic [1:0]      ack_src;
    logic            ack_stb;

    modport master (
        output src_req, cpu_a, cpu_d_in, cpu_m1, cpu_iorq, cpu_rd, cpu_wr,
        input  int_req, d_out, d_oe, ack_src, ack_stb
    );

    modport slave (
        input  src_req, cpu_a, cpu_d_in, cpu_m1, cpu_iorq, cpu_rd, cpu_wr,
        output int_req, d_out, d_oe, ack_src, ack_stb
    );
endinterface

// File: rtl/im2_vector_responder.sv
// -----------------------------------------------------------------------------
// im2_vector_responder
// Z80 IM2 interrupt-acknowledge responder. Edge-detected peripheral requests
// are collected into a pending register, qualified by a mask, and raise a
// registered level request. On an acknowledge cycle (M1+IORQ) the lowest
// indexed unmasked pending source wins: its vector byte is driven onto the
// bus and its pending bit is cleared. Pending (W1C) and mask are also
// accessible through two fully decoded I/O ports.
// Ports:
//   clk28 : 28 MHz system clock
//   rst   : synchronous active-high reset
//   bus   : im2_vector_responder_if.slave (requests, CPU bus, responses)
// -----------------------------------------------------------------------------
module im2_vector_responder #(
    parameter int          NSRC      = 4,
    parameter logic [7:0]  VEC_BASE  = 8'hF8,
    parameter logic [15:0] PORT_PEND = 16'h8E3B,
    parameter logic [15:0] PORT_MASK = 16'h8F3B
) (
    input  logic                        clk28,
    input  logic                        rst,
    im2_vector_responder_if.slave       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_IO   = 2'd2;

    // Lowest index wins among the active requests.
    function automatic logic [1:0] prio_idx(input logic [NSRC-1:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = req[i] ? 2'(i) : idx;
        end
        return idx;
    endfunction

    logic [1:0]      r_state;
    logic [NSRC-1:0] r_req_d;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic            r_int_req;
    logic [7:0]      r_d_out;
    logic            r_d_oe;
    logic [1:0]      r_ack_src;
    logic            r_ack_stb;
    logic            r_io_sel_mask;

    logic [NSRC-1:0] w_active;
    logic            w_has_winner;
    logic [1:0]      w_win_idx;
    logic [NSRC-1:0] w_win_onehot;
    logic [7:0]      w_vector;
    logic [NSRC-1:0] w_edge;
    logic            w_inta;
    logic            w_port_pend;
    logic            w_port_mask;
    logic            w_io_start;
    logic [NSRC-1:0] w_clear;
    logic [NSRC-1:0] w_pending_nxt;
    logic [NSRC-1:0] w_mask_nxt;
    logic [7:0]      w_pend_rd;
    logic [7:0]      w_mask_rd;
    logic            w_unused_data;

    assign w_active     = r_pending & r_mask;
    assign w_has_winner = |w_active;
    assign w_win_idx    = prio_idx(w_active);
    assign w_vector     = w_has_winner ? (VEC_BASE | {5'b00000, w_win_idx, 1'b0}) : 8'hFF;
    assign w_edge       = bus.src_req & ~r_req_d;
    assign w_port_pend  = (bus.cpu_a == PORT_PEND);
    assign w_port_mask  = (bus.cpu_a == PORT_MASK);
    assign w_inta       = (r_state == ST_IDLE) && bus.cpu_m1 && bus.cpu_iorq;
    assign w_io_start   = (r_state == ST_IDLE) && bus.cpu_iorq && !bus.cpu_m1 &&
                          (bus.cpu_rd || bus.cpu_wr) && (w_port_pend || w_port_mask);
    assign w_pend_rd    = {{(8-NSRC){1'b0}}, r_pending};
    assign w_mask_rd    = {{(8-NSRC){1'b0}}, r_mask};
    // Write-data bits above the source count carry no function.
    assign w_unused_data = ^bus.cpu_d_in[7:NSRC];

    // One-hot form of the winner, empty when nothing is eligible.
    always_comb begin
        w_win_onehot = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            w_win_onehot[i] = w_has_winner && (w_win_idx == 2'(i));
        end
    end

    // Clear sources: acknowledge winner, or W1C write on pending-port entry.
    always_comb begin
        w_clear = {NSRC{1'b0}};
        if (w_inta) begin
            w_clear = w_win_onehot;
        end else if (w_io_start && bus.cpu_wr && w_port_pend) begin
            w_clear = bus.cpu_d_in[NSRC-1:0];
        end else begin
            w_clear = {NSRC{1'b0}};
        end
    end

    // Next mask: only a write on mask-port entry changes it.
    always_comb begin
        w_mask_nxt = r_mask;
        if (w_io_start && bus.cpu_wr && w_port_mask) begin
            w_mask_nxt = bus.cpu_d_in[NSRC-1:0];
        end else begin
            w_mask_nxt = r_mask;
        end
    end

    // A new edge is OR-ed in after the clear, so set beats clear on collision.
    assign w_pending_nxt = (r_pending & ~w_clear) | w_edge;

    // Request history, pending/mask registers and the registered INT level.
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_req_d   <= {NSRC{1'b0}};
            r_pending <= {NSRC{1'b0}};
            r_mask    <= {NSRC{1'b1}};
            r_int_req <= 1'b0;
        end else begin
            r_req_d   <= bus.src_req;
            r_pending <= w_pending_nxt;
            r_mask    <= w_mask_nxt;
            // Built from current registers: adds one cycle after a pending/mask change.
            r_int_req <= |(r_pending & r_mask);
        end
    end

    // Bus-cycle FSM: acknowledge vector drive and register-port reads.
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_d_out       <= 8'hFF;
            r_d_oe        <= 1'b0;
            r_ack_src     <= 2'd0;
            r_ack_stb     <= 1'b0;
            r_io_sel_mask <= 1'b0;
        end else begin
            r_ack_stb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_inta) begin
                        // Vector is latched here and held for the whole ACK.
                        r_state <= ST_ACK;
                        r_d_oe  <= 1'b1;
                        r_d_out <= w_vector;
                        if (w_has_winner) begin
                            r_ack_src <= w_win_idx;
                            r_ack_stb <= 1'b1;
                        end
                    end else if (w_io_start) begin
                        r_state       <= ST_IO;
                        r_io_sel_mask <= w_port_mask;
                        if (bus.cpu_rd) begin
                            r_d_oe  <= 1'b1;
                            r_d_out <= w_port_mask ? w_mask_rd : w_pend_rd;
                        end
                    end
                end
                ST_ACK: begin
                    if (!bus.cpu_iorq) begin
                        r_state <= ST_IDLE;
                        r_d_oe  <= 1'b0;
                        r_d_out <= 8'hFF;
                    end
                end
                ST_IO: begin
                    if (!bus.cpu_iorq) begin
                        r_state <= ST_IDLE;
                        r_d_oe  <= 1'b0;
                        r_d_out <= 8'hFF;
                    end else if (bus.cpu_rd) begin
                        r_d_oe  <= 1'b1;
                        r_d_out <= r_io_sel_mask ? w_mask_rd : w_pend_rd;
                    end else begin
                        r_d_oe  <= 1'b0;
                        r_d_out <= 8'hFF;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_d_oe  <= 1'b0;
                    r_d_out <= 8'hFF;
                end
            endcase
        end
    end

    assign bus.int_req = r_int_req;
    assign bus.d_out   = r_d_out;
    assign bus.d_oe    = r_d_oe;
    assign bus.ack_src = r_ack_src;
    assign bus.ack_stb = r_ack_stb;

endmodule

// File: tb/tb_im2_vector_responder.sv
// -----------------------------------------------------------------------------
// tb_im2_vector_responder
// Directed bench for im2_vector_responder: single source acknowledge,
// priority, masking, spurious acknowledge, set/clear collision, reset during
// acknowledge, level-held request and address decode. Inputs change 1 ns
// after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_im2_vector_responder;

    localparam logic [15:0] PORT_PEND = 16'h8E3B;
    localparam logic [15:0] PORT_MASK = 16'h8F3B;

    logic clk28 = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    im2_vector_responder_if #(.NSRC(4)) bus ();

    im2_vector_responder #(
        .NSRC      (4),
        .VEC_BASE  (8'hF8),
        .PORT_PEND (PORT_PEND),
        .PORT_MASK (PORT_MASK)
    ) dut (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (bus)
    );

    always #18 clk28 = ~clk28;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_a    = a;
        bus.cpu_d_in = d;
        bus.cpu_iorq = 1'b1;
        bus.cpu_wr   = 1'b1;
        cyc(1);
        bus.cpu_iorq = 1'b0;
        bus.cpu_wr   = 1'b0;
        cyc(1);
    endtask

    task automatic io_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        bus.cpu_a    = a;
        bus.cpu_iorq = 1'b1;
        bus.cpu_rd   = 1'b1;
        cyc(1);
        d  = bus.d_out;
        oe = bus.d_oe;
        bus.cpu_iorq = 1'b0;
        bus.cpu_rd   = 1'b0;
        cyc(1);
    endtask

    task automatic inta_start();
        bus.cpu_m1   = 1'b1;
        bus.cpu_iorq = 1'b1;
        cyc(1);
    endtask

    task automatic inta_end();
        bus.cpu_m1   = 1'b0;
        bus.cpu_iorq = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic [7:0] rd_d;
        logic       rd_oe;

        rst          = 1'b1;
        bus.src_req  = 4'b0000;
        bus.cpu_a    = 16'h0000;
        bus.cpu_d_in = 8'h00;
        bus.cpu_m1   = 1'b0;
        bus.cpu_iorq = 1'b0;
        bus.cpu_rd   = 1'b0;
        bus.cpu_wr   = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Reset state
        check_val("rst_int_req", {15'd0, bus.int_req}, 16'd0);
        check_val("rst_d_oe",    {15'd0, bus.d_oe},    16'd0);
        check_val("rst_d_out",   {8'd0, bus.d_out},    16'h00FF);
        check_val("rst_ack_stb", {15'd0, bus.ack_stb}, 16'd0);
        check_val("rst_ack_src", {14'd0, bus.ack_src}, 16'd0);
        io_read(PORT_MASK, rd_d, rd_oe);
        check_val("rst_mask_rd", {8'd0, rd_d}, 16'h000F);
        check_val("rst_mask_oe", {15'd0, rd_oe}, 16'd1);
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("rst_pend_rd", {8'd0, rd_d}, 16'h0000);

        // 1. Single source
        bus.src_req = 4'b0100;
        cyc(1);
        bus.src_req = 4'b0000;
        check_val("t1_int_1cyc", {15'd0, bus.int_req}, 16'd0);
        cyc(1);
        check_val("t1_int_2cyc", {15'd0, bus.int_req}, 16'd1);
        inta_start();
        check_val("t1_d_oe",   {15'd0, bus.d_oe},    16'd1);
        check_val("t1_vector", {8'd0, bus.d_out},    16'h00FC);
        check_val("t1_stb",    {15'd0, bus.ack_stb}, 16'd1);
        check_val("t1_src",    {14'd0, bus.ack_src}, 16'd2);
        cyc(1);
        check_val("t1_stb_off", {15'd0, bus.ack_stb}, 16'd0);
        check_val("t1_int_off", {15'd0, bus.int_req}, 16'd0);
        check_val("t1_oe_hold", {15'd0, bus.d_oe},    16'd1);
        check_val("t1_vec_hold", {8'd0, bus.d_out},   16'h00FC);
        inta_end();
        check_val("t1_oe_drop", {15'd0, bus.d_oe},    16'd0);
        check_val("t1_dout_ff", {8'd0, bus.d_out},    16'h00FF);

        // 2. Priority
        bus.src_req = 4'b1010;
        cyc(1);
        bus.src_req = 4'b0000;
        cyc(1);
        check_val("t2_int_on", {15'd0, bus.int_req}, 16'd1);
        inta_start();
        check_val("t2_vec1", {8'd0, bus.d_out},    16'h00FA);
        check_val("t2_src1", {14'd0, bus.ack_src}, 16'd1);
        check_val("t2_stb1", {15'd0, bus.ack_stb}, 16'd1);
        inta_end();
        check_val("t2_int_between", {15'd0, bus.int_req}, 16'd1);
        inta_start();
        check_val("t2_vec2", {8'd0, bus.d_out},    16'h00FE);
        check_val("t2_src2", {14'd0, bus.ack_src}, 16'd3);
        inta_end();
        check_val("t2_int_drop", {15'd0, bus.int_req}, 16'd0);

        // 3. Masking
        io_write(PORT_MASK, 8'h0E);
        bus.src_req = 4'b0001;
        cyc(1);
        bus.src_req = 4'b0000;
        cyc(2);
        check_val("t3_int_masked", {15'd0, bus.int_req}, 16'd0);
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("t3_pend_rd", {8'd0, rd_d}, 16'h0001);
        check_val("t3_pend_oe", {15'd0, rd_oe}, 16'd1);
        io_write(PORT_MASK, 8'h0F);
        check_val("t3_int_unmask", {15'd0, bus.int_req}, 16'd1);
        io_write(PORT_PEND, 8'h01);
        check_val("t3_int_w1c", {15'd0, bus.int_req}, 16'd0);
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("t3_pend_w1c", {8'd0, rd_d}, 16'h0000);

        // 4. Spurious acknowledge with a masked pending source
        io_write(PORT_MASK, 8'h0E);
        bus.src_req = 4'b0001;
        cyc(1);
        bus.src_req = 4'b0000;
        cyc(1);
        inta_start();
        check_val("t4_oe",   {15'd0, bus.d_oe},    16'd1);
        check_val("t4_vec",  {8'd0, bus.d_out},    16'h00FF);
        check_val("t4_stb",  {15'd0, bus.ack_stb}, 16'd0);
        check_val("t4_int",  {15'd0, bus.int_req}, 16'd0);
        inta_end();
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("t4_pend_kept", {8'd0, rd_d}, 16'h0001);
        io_write(PORT_MASK, 8'h0F);
        check_val("t4_int_unmask", {15'd0, bus.int_req}, 16'd1);

        // 5. Collision: new edge on source 0 lands with its acknowledge
        bus.src_req  = 4'b0001;
        bus.cpu_m1   = 1'b1;
        bus.cpu_iorq = 1'b1;
        cyc(1);
        check_val("t5_stb", {15'd0, bus.ack_stb}, 16'd1);
        check_val("t5_src", {14'd0, bus.ack_src}, 16'd0);
        check_val("t5_vec", {8'd0, bus.d_out},    16'h00F8);
        bus.src_req  = 4'b0000;
        bus.cpu_m1   = 1'b0;
        bus.cpu_iorq = 1'b0;
        cyc(1);
        check_val("t5_int_kept", {15'd0, bus.int_req}, 16'd1);
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("t5_pend_kept", {8'd0, rd_d}, 16'h0001);

        // 6. Reset during acknowledge
        inta_start();
        check_val("t6_oe_before", {15'd0, bus.d_oe}, 16'd1);
        rst = 1'b1;
        cyc(1);
        check_val("t6_oe_after",   {15'd0, bus.d_oe},    16'd0);
        check_val("t6_dout_after", {8'd0, bus.d_out},    16'h00FF);
        check_val("t6_stb_after",  {15'd0, bus.ack_stb}, 16'd0);
        bus.cpu_m1   = 1'b0;
        bus.cpu_iorq = 1'b0;
        rst          = 1'b0;
        cyc(1);
        io_read(PORT_MASK, rd_d, rd_oe);
        check_val("t6_mask_rd", {8'd0, rd_d}, 16'h000F);
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("t6_pend_rd", {8'd0, rd_d}, 16'h0000);
        check_val("t6_int", {15'd0, bus.int_req}, 16'd0);

        // 7. Level-held request does not re-set after W1C
        bus.src_req = 4'b0010;
        cyc(2);
        check_val("t7_int_on", {15'd0, bus.int_req}, 16'd1);
        io_write(PORT_PEND, 8'h02);
        cyc(1);
        check_val("t7_int_off", {15'd0, bus.int_req}, 16'd0);
        io_read(PORT_PEND, rd_d, rd_oe);
        check_val("t7_pend_rd", {8'd0, rd_d}, 16'h0000);
        bus.src_req = 4'b0000;
        cyc(1);

        // 8. Non-matching I/O address is ignored
        bus.cpu_a    = 16'h8E3C;
        bus.cpu_iorq = 1'b1;
        bus.cpu_rd   = 1'b1;
        cyc(1);
        check_val("t8_no_decode_oe", {15'd0, bus.d_oe}, 16'd0);
        bus.cpu_iorq = 1'b0;
        bus.cpu_rd   = 1'b0;
        cyc(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
